// File: rtl/quad_enc_decoder.sv
// quad_enc_decoder: receive-side quadrature decoder for one motor encoder.
//
// The raw A/B pins are synchronized, optionally glitch filtered, and decoded
// 4x into a signed position count. Velocity is the signed number of legal
// steps seen in a fixed window of WINDOW_CYCLES clocks, saturated to VEL_W.
//
// Optional feature: define QDEC_GLITCH_FILTER_EN to insert a per-channel
// stability filter (FILT_CYCLES consecutive cycles) after the synchronizers.
//
// Parameters:
//   POS_W         position counter width (two's complement)
//   VEL_W         velocity output width (two's complement)
//   WINDOW_CYCLES clk cycles per velocity window, >= 2
//   FILT_CYCLES   filter stability length, >= 1 (filter builds only)
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   enc_a      raw encoder channel A (asynchronous)
//   enc_b      raw encoder channel B (asynchronous)
//   clr        synchronous clear of pos and err
//   pos        accumulated position in quadrature steps
//   vel        signed step count of the last completed window
//   vel_valid  one-cycle pulse when vel updates
//   dir        direction of the last legal step, 1 = forward
//   err        sticky illegal-transition flag

module quad_enc_decoder #(
    parameter int unsigned POS_W         = 32,
    parameter int unsigned VEL_W         = 16,
    parameter int unsigned WINDOW_CYCLES = 1_000_000,
    parameter int unsigned FILT_CYCLES   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enc_a,
    input  logic             enc_b,
    input  logic             clr,
    output logic [POS_W-1:0] pos,
    output logic [VEL_W-1:0] vel,
    output logic             vel_valid,
    output logic             dir,
    output logic             err
);

    localparam int unsigned WIN_W   = $clog2(WINDOW_CYCLES);
    // Accumulator must hold +/-WINDOW_CYCLES and still exceed the output range
    localparam int unsigned ACC_RAW = $clog2(WINDOW_CYCLES + 1) + 1;
    localparam int unsigned ACC_W   = (ACC_RAW > VEL_W) ? ACC_RAW : VEL_W + 1;

    localparam logic signed [ACC_W-1:0] VEL_MAX = ACC_W'((1 << (VEL_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] VEL_MIN = ~VEL_MAX;
    localparam logic [WIN_W-1:0]        WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);

    // Elaboration-time parameter sanity checks
    if (WINDOW_CYCLES < 2) begin : g_win_chk
        $error("WINDOW_CYCLES must be >= 2");
    end
    if (FILT_CYCLES < 1) begin : g_filt_chk
        $error("FILT_CYCLES must be >= 1");
    end

    // ------------------------------------------------------------------
    // Two-flop synchronizer; bit 1 = A, bit 0 = B
    // ------------------------------------------------------------------
    logic [1:0] sync1_q;
    logic [1:0] sync2_q;
    // Tracks how far real pin data has propagated into the synchronizer
    logic [1:0] sync_vld_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= 2'b00;
            sync2_q    <= 2'b00;
            sync_vld_q <= 2'b00;
        end else begin
            sync1_q    <= {enc_a, enc_b};
            sync2_q    <= sync1_q;
            sync_vld_q <= {sync_vld_q[0], 1'b1};
        end
    end

    logic [1:0] dec_in;
    logic       dec_vld;

`ifdef QDEC_GLITCH_FILTER_EN
    // ------------------------------------------------------------------
    // Per-channel stability filter
    // ------------------------------------------------------------------
    localparam int unsigned FC_W = $clog2(FILT_CYCLES) + 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FILT_CYCLES - 1);

    logic       filt_init_q;
    logic [1:0] filt_v;

    // Filter is seeded from the first valid synchronized sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_init_q <= 1'b0;
        end else if (sync_vld_q[1]) begin
            filt_init_q <= 1'b1;
        end
    end

    for (genvar ch = 0; ch < 2; ch++) begin : g_filt
        logic            f_q;
        logic            f_d;
        logic [FC_W-1:0] cnt_q;
        logic [FC_W-1:0] cnt_d;

        // Output flips only after FILT_CYCLES consecutive differing cycles
        always_comb begin
            f_d   = f_q;
            cnt_d = '0;
            if (!filt_init_q) begin
                f_d = sync2_q[ch];
            end else if (sync2_q[ch] != f_q) begin
                if (cnt_q == FC_LAST) begin
                    f_d = sync2_q[ch];
                end else begin
                    cnt_d = cnt_q + FC_W'(1);
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                f_q   <= 1'b0;
                cnt_q <= '0;
            end else begin
                f_q   <= f_d;
                cnt_q <= cnt_d;
            end
        end

        assign filt_v[ch] = f_q;
    end

    assign dec_in  = filt_v;
    assign dec_vld = filt_init_q;
`else
    assign dec_in  = sync2_q;
    assign dec_vld = sync_vld_q[1];
`endif

    // ------------------------------------------------------------------
    // Decoder, position, direction, error and velocity state
    // ------------------------------------------------------------------
    logic [1:0]              prev_q,      prev_d;
    logic                    primed_q,    primed_d;
    logic [POS_W-1:0]        pos_q,       pos_d;
    logic                    dir_q,       dir_d;
    logic                    err_q,       err_d;
    logic [WIN_W-1:0]        win_q,       win_d;
    logic signed [ACC_W-1:0] acc_q,       acc_d;
    logic [VEL_W-1:0]        vel_q,       vel_d;
    logic                    vel_valid_q, vel_valid_d;

    logic                    step_fwd;
    logic                    step_rev;
    logic                    illegal;
    logic signed [ACC_W-1:0] acc_step;

    // Classify the transition prev -> dec_in; nothing counts until primed
    always_comb begin
        step_fwd = 1'b0;
        step_rev = 1'b0;
        illegal  = 1'b0;
        if (primed_q && dec_vld) begin
            case ({prev_q, dec_in})
                4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: step_fwd = 1'b1;
                4'b10_00, 4'b11_10, 4'b01_11, 4'b00_01: step_rev = 1'b1;
                4'b00_11, 4'b11_00, 4'b10_01, 4'b01_10: illegal  = 1'b1;
                default: ;
            endcase
        end
    end

    // Next-state logic for position, flags and velocity window
    always_comb begin
        prev_d      = prev_q;
        primed_d    = primed_q;
        pos_d       = pos_q;
        dir_d       = dir_q;
        err_d       = err_q;
        win_d       = win_q + WIN_W'(1);
        acc_d       = acc_q;
        vel_d       = vel_q;
        vel_valid_d = 1'b0;
        acc_step    = acc_q;

        // First valid sample only seeds prev; later samples always track
        if (dec_vld) begin
            prev_d   = dec_in;
            primed_d = 1'b1;
        end

        // Accumulator counts every legal step, independent of clr
        if (step_fwd) begin
            acc_step = acc_q + ACC_W'(1);
        end else if (step_rev) begin
            acc_step = acc_q - ACC_W'(1);
        end

        // clr wins over a coincident step: the step is dropped from pos
        if (clr) begin
            pos_d = '0;
            err_d = 1'b0;
        end else begin
            if (step_fwd) begin
                pos_d = pos_q + POS_W'(1);
                dir_d = 1'b1;
            end else if (step_rev) begin
                pos_d = pos_q - POS_W'(1);
                dir_d = 1'b0;
            end
            if (illegal) begin
                err_d = 1'b1;
            end
        end

        // Terminal count: publish saturated window total and restart
        if (win_q == WIN_LAST) begin
            win_d       = '0;
            acc_d       = '0;
            vel_valid_d = 1'b1;
            if (acc_step > VEL_MAX) begin
                vel_d = VEL_MAX[VEL_W-1:0];
            end else if (acc_step < VEL_MIN) begin
                vel_d = VEL_MIN[VEL_W-1:0];
            end else begin
                vel_d = acc_step[VEL_W-1:0];
            end
        end else begin
            acc_d = acc_step;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q      <= 2'b00;
            primed_q    <= 1'b0;
            pos_q       <= '0;
            dir_q       <= 1'b1;
            err_q       <= 1'b0;
            win_q       <= '0;
            acc_q       <= '0;
            vel_q       <= '0;
            vel_valid_q <= 1'b0;
        end else begin
            prev_q      <= prev_d;
            primed_q    <= primed_d;
            pos_q       <= pos_d;
            dir_q       <= dir_d;
            err_q       <= err_d;
            win_q       <= win_d;
            acc_q       <= acc_d;
            vel_q       <= vel_d;
            vel_valid_q <= vel_valid_d;
        end
    end

    assign pos       = pos_q;
    assign vel       = vel_q;
    assign vel_valid = vel_valid_q;
    assign dir       = dir_q;
    assign err       = err_q;

endmodule

// File: tb/tb_quad_enc_decoder.sv
// Scoreboard bench for quad_enc_decoder: directed pin vectors push expected
// position/flag events and per-window velocities; monitors pop and compare.
module tb_quad_enc_decoder;

    localparam int WIN = 1000;
`ifdef QDEC_GLITCH_FILTER_EN
    localparam int LAT = 7;
`else
    localparam int LAT = 3;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enc_a = 1'b1;
    logic        enc_b = 1'b1;
    logic        clr = 1'b0;

    logic [31:0] pos;
    logic [15:0] vel;
    logic        vel_valid;
    logic        dir;
    logic        err;

    logic [31:0] s_pos;
    logic [3:0]  s_vel;
    logic        s_vel_valid;
    logic        s_dir;
    logic        s_err;

    always #5 clk = ~clk;

    quad_enc_decoder #(.POS_W(32), .VEL_W(16), .WINDOW_CYCLES(WIN), .FILT_CYCLES(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .enc_a(enc_a), .enc_b(enc_b), .clr(clr),
        .pos(pos), .vel(vel), .vel_valid(vel_valid), .dir(dir), .err(err)
    );

    quad_enc_decoder #(.POS_W(32), .VEL_W(4), .WINDOW_CYCLES(WIN), .FILT_CYCLES(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .enc_a(enc_a), .enc_b(enc_b), .clr(clr),
        .pos(s_pos), .vel(s_vel), .vel_valid(s_vel_valid), .dir(s_dir), .err(s_err)
    );

    typedef struct {
        logic [31:0] pos;
        logic        dir;
        logic        err;
        int          cyc;
    } pev_t;

    typedef struct {
        int vel;
        int cyc;
    } vev_t;

    typedef struct {
        logic        a;
        logic        b;
        logic        c;
        logic [31:0] pos;
        logic        dir;
        logic        err;
        int          delta;
    } vec_t;

    pev_t pos_q[$];
    vev_t vel_q[$];
    vev_t sat_q[$];

    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   win_steps[16];
    logic mon_en = 1'b0;

    logic [31:0] last_pos = 32'd0;
    logic        last_dir = 1'b1;
    logic        last_err = 1'b0;
    logic [31:0] exp_pos;

    vec_t vt[19];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int sat(input int x, input int hi);
        if (x > hi) return hi;
        if (x < -hi - 1) return -hi - 1;
        return x;
    endfunction

    function automatic logic [1:0] fwd_next(input logic [1:0] s);
        case (s)
            2'b00:   return 2'b10;
            2'b10:   return 2'b11;
            2'b11:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] rev_next(input logic [1:0] s);
        case (s)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    // Called at a negedge: change pins, register expectations, hold for gap cycles
    task automatic drive(input logic na, input logic nb, input logic with_clr,
                         input logic [31:0] epos, input logic edir, input logic eerr,
                         input int delta, input int gap);
        int   land;
        pev_t ev;
        land  = cyc + LAT;
        enc_a = na;
        enc_b = nb;
        if (epos !== last_pos || edir !== last_dir || eerr !== last_err) begin
            ev.pos = epos; ev.dir = edir; ev.err = eerr; ev.cyc = land;
            pos_q.push_back(ev);
            last_pos = epos; last_dir = edir; last_err = eerr;
        end
        if (delta != 0 && (land - 1) / WIN < 16)
            win_steps[(land - 1) / WIN] += delta;
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            clr = with_clr && (cyc == land - 1);
        end
        clr = 1'b0;
    endtask

    // Cycle counter and per-window velocity expectations
    initial begin
        vev_t ve;
        forever begin
            @(posedge clk);
            if (rst_n) begin
                cyc++;
                if (cyc % WIN == 0 && cyc / WIN <= 16) begin
                    ve.cyc = cyc;
                    ve.vel = sat(win_steps[cyc / WIN - 1], 32767);
                    vel_q.push_back(ve);
                    ve.vel = sat(win_steps[cyc / WIN - 1], 7);
                    sat_q.push_back(ve);
                end
            end
        end
    end

    // Monitor: compare every visible pos/dir/err change and every vel_valid
    initial begin
        logic [33:0] prev_obs;
        pev_t        pe;
        vev_t        ve;
        prev_obs = {32'd0, 1'b1, 1'b0};
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if ({pos, dir, err} !== prev_obs) begin
                    if (pos_q.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL pos_unexpected: got pos=%0h dir=%0b err=%0b, expected no change (cycle %0d)",
                                 pos, dir, err, cyc);
                    end else begin
                        pe = pos_q.pop_front();
                        chk("pos_event", {pos, dir, err, 32'(cyc)}, {pe.pos, pe.dir, pe.err, 32'(pe.cyc)});
                    end
                    prev_obs = {pos, dir, err};
                end
                if (vel_valid) begin
                    if (vel_q.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL vel_unexpected: got vel_valid at cycle %0d, expected none", cyc);
                    end else begin
                        ve = vel_q.pop_front();
                        chk("vel16", {32'($signed(vel)), 32'(cyc)}, {32'(ve.vel), 32'(ve.cyc)});
                    end
                end
                if (s_vel_valid) begin
                    if (sat_q.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL vel4_unexpected: got vel_valid at cycle %0d, expected none", cyc);
                    end else begin
                        ve = sat_q.pop_front();
                        chk("vel4_sat", {32'($signed(s_vel)), 32'(cyc)}, {32'(ve.vel), 32'(ve.cyc)});
                    end
                end
            end
        end
    end

    initial begin
        logic [1:0] st;
        for (int i = 0; i < 16; i++) win_steps[i] = 0;
        //        a     b     clr   pos            dir   err   delta
        vt[0]  = '{1'b0, 1'b1, 1'b0, 32'd1,        1'b1, 1'b0,  1};
        vt[1]  = '{1'b0, 1'b0, 1'b0, 32'd2,        1'b1, 1'b0,  1};
        vt[2]  = '{1'b1, 1'b0, 1'b0, 32'd3,        1'b1, 1'b0,  1};
        vt[3]  = '{1'b1, 1'b1, 1'b0, 32'd4,        1'b1, 1'b0,  1};
        vt[4]  = '{1'b0, 1'b1, 1'b0, 32'd5,        1'b1, 1'b0,  1};
        vt[5]  = '{1'b0, 1'b0, 1'b0, 32'd6,        1'b1, 1'b0,  1};
        vt[6]  = '{1'b1, 1'b0, 1'b0, 32'd7,        1'b1, 1'b0,  1};
        vt[7]  = '{1'b1, 1'b1, 1'b0, 32'd8,        1'b1, 1'b0,  1};
        vt[8]  = '{1'b1, 1'b0, 1'b0, 32'd7,        1'b0, 1'b0, -1};
        vt[9]  = '{1'b0, 1'b0, 1'b0, 32'd6,        1'b0, 1'b0, -1};
        vt[10] = '{1'b0, 1'b1, 1'b0, 32'd5,        1'b0, 1'b0, -1};
        vt[11] = '{1'b0, 1'b0, 1'b0, 32'd6,        1'b1, 1'b0,  1};
        vt[12] = '{1'b1, 1'b1, 1'b0, 32'd6,        1'b1, 1'b1,  0};
        vt[13] = '{1'b0, 1'b0, 1'b0, 32'd6,        1'b1, 1'b1,  0};
        vt[14] = '{1'b1, 1'b0, 1'b1, 32'd0,        1'b1, 1'b0,  1};
        vt[15] = '{1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, -1};
        vt[16] = '{1'b1, 1'b0, 1'b0, 32'd0,        1'b1, 1'b0,  1};
        vt[17] = '{1'b1, 1'b1, 1'b0, 32'd1,        1'b1, 1'b0,  1};
        vt[18] = '{1'b1, 1'b1, 1'b1, 32'd0,        1'b1, 1'b0,  0};

        // Reset values while held in reset, pins idle at 11
        repeat (3) @(negedge clk);
        chk("reset_pos", 64'(pos), 64'd0);
        chk("reset_vel", 64'(vel), 64'd0);
        chk("reset_vel_valid", 64'(vel_valid), 64'd0);
        chk("reset_dir", 64'(dir), 64'd1);
        chk("reset_err", 64'(err), 64'd0);

        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (100) @(negedge clk);
        chk("prime_idle", {32'(pos), 31'd0, dir, err}, {32'd0, 31'd0, 1'b1, 1'b0});

        for (int i = 0; i < 19; i++)
            drive(vt[i].a, vt[i].b, vt[i].c, vt[i].pos, vt[i].dir, vt[i].err, vt[i].delta, 100);

`ifdef QDEC_GLITCH_FILTER_EN
        // 3-cycle pulse on A must be discarded by the filter
        enc_a = 1'b0;
        repeat (3) @(negedge clk);
        enc_a = 1'b1;
        repeat (20) @(negedge clk);
`endif

        // Velocity: forward then reverse, one step every 20 cycles
        exp_pos = 32'd0;
        st = {enc_a, enc_b};
        for (int i = 0; i < 125; i++) begin
            st = fwd_next(st);
            exp_pos = exp_pos + 32'd1;
            drive(st[1], st[0], 1'b0, exp_pos, 1'b1, 1'b0, 1, 20);
        end
        for (int i = 0; i < 125; i++) begin
            st = rev_next(st);
            exp_pos = exp_pos - 32'd1;
            drive(st[1], st[0], 1'b0, exp_pos, 1'b0, 1'b0, -1, 20);
        end

        // Idle through at least one whole window
        for (int i = 0; i < 20000 && cyc < 9 * WIN + 2; i++) @(negedge clk);
        chk("run_budget", 64'(cyc >= 9 * WIN + 2), 64'd1);
        chk("pos_q_drained", 64'(pos_q.size()), 64'd0);
        chk("vel_q_drained", 64'(vel_q.size()), 64'd0);
        chk("sat_q_drained", 64'(sat_q.size()), 64'd0);
        chk("sat_inst_state", {32'(s_pos), 31'd0, s_dir, s_err}, {exp_pos, 31'd0, 1'b0, 1'b0});

        // Reset mid-operation returns everything to reset values
        mon_en = 1'b0;
        st = rev_next(st);
        enc_a = st[1];
        enc_b = st[0];
        repeat (LAT + 2) @(negedge clk);
        chk("pre_reset_pos", 64'(pos), 64'hFFFF_FFFF);
        rst_n = 1'b0;
        #1;
        chk("midrst_pos", 64'(pos), 64'd0);
        chk("midrst_dir_err_valid", {61'd0, dir, err, vel_valid}, {61'd0, 1'b1, 1'b0, 1'b0});
        chk("midrst_vel", {48'd0, vel}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/quad_enc_decoder.md
# quad_enc_decoder

Receive-side quadrature decoder for the motor encoder channels (encoder_a_m1/encoder_b_m1, encoder_a_m2/encoder_b_m2). It synchronizes the raw A/B pins, decodes 4x quadrature steps into a signed position count, and measures velocity as steps per fixed sample window. One instance per motor sits inside `top`, between the PMOD encoder pins and the speed/heading control logic.

## Interface
- `POS_W`, 32: position counter width, two's complement.
- `VEL_W`, 16: velocity output width, two's complement.
- `WINDOW_CYCLES`, 1_000_000: clk cycles per velocity window (10 ms at 100 MHz); must be ≥ 2.
- `FILT_CYCLES`, 4: stable cycles required by the glitch filter (only used with the filter compiled in); must be ≥ 1.

Ports:
- `clk`  in  1  system clock, 100 MHz.
- `rst_n`  in  1  reset; asynchronous assertion, active-low.
- `enc_a`  in  1  raw encoder channel A, asynchronous to `clk`.
- `enc_b`  in  1  raw encoder channel B, asynchronous to `clk`.
- `clr`  in  1  synchronous clear of `pos` and `err`.
- `pos`  out  POS_W  signed accumulated position in quadrature steps.
- `vel`  out  VEL_W  signed step count of the last completed window.
- `vel_valid`  out  1  one-cycle pulse when `vel` updates.
- `dir`  out  1  direction of the last legal step; 1 = forward.
- `err`  out  1  sticky flag for illegal transitions.

## Operation
- Input path: a 2-flop synchronizer per channel, then the optional glitch filter, then a 2-bit registered previous state `prev`.
- Priming: after reset, a `primed` flag is 0. The first filtered sample loads `prev`, sets `primed`, and does not count. Idle encoder pins at 11 after reset therefore produce no step.
- Forward (A leads B), sequence (A,B): 00→10→11→01→00. Each transition adds +1 to `pos` and sets `dir`=1.
- Reverse: the opposite sequence. Each transition adds −1 and sets `dir`=0.
- No change in (A,B): no step.
- Illegal transition (both bits change in one sample): no `pos` change, `dir` holds, `err` set and held. `prev` still updates to the new state.
- `pos` wraps modulo 2^POS_W: 0x7FFF_FFFF +1 → 0x8000_0000; 0 −1 → all ones.
- `clr`: `pos` ← 0 and `err` ← 0. A step in the same cycle is dropped, so `pos` = 0 after that cycle. `clr` does not affect `vel`, the window counter, or the window accumulator.
- Velocity:
  - A window counter counts 0..WINDOW_CYCLES−1.
  - The signed accumulator `acc` adds every legal step.
  - On the terminal count, `vel` ← saturate(`acc` including any step in that cycle). Saturation limits are +(2^(VEL_W−1)−1) and −2^(VEL_W−1).
  - In the same cycle, `acc` ← 0 and `vel_valid` pulses for 1 cycle.
- Reset mid-operation: all state returns to reset values immediately, and the decoder re-primes.

## Timing
- Reset values: `pos`=0, `vel`=0, `vel_valid`=0, `dir`=1, `err`=0. Internally `primed`=0, window counter=0, `acc`=0, synchronizers=00.
- Latency without the filter: a pin change is reflected in `pos`/`dir`/`err` on the 3rd rising clk edge after the change (2 synchronizer + 1 decode).
- The filter adds FILT_CYCLES cycles to that latency.
- Minimum resolvable step spacing: 1 cycle between state changes at decoder input. Faster pin toggling is undefined (typically flagged as `err`).
- First `vel_valid` occurs WINDOW_CYCLES cycles after `rst_n` deasserts, then every WINDOW_CYCLES cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `QDEC_GLITCH_FILTER_EN` defined:
  - Each synchronized channel passes through a per-channel filter.
  - The filtered value changes only after the raw value has differed from it for FILT_CYCLES consecutive cycles.
  - Shorter pulses are discarded.
- Not defined: synchronized values feed the decoder directly. FILT_CYCLES is ignored.

## Test plan
- Reset with pins held at 11, run 100 cycles → `pos`=0, `err`=0, `dir`=1 (priming, no false step).
- 8 forward steps, 1 µs apart (00→10→11→01→00 twice) → `pos`=8, `dir`=1. Then 3 reverse steps → `pos`=5, `dir`=0. Each update lands 3 cycles after its pin edge (filter out).
- Force (A,B) 00→11 → `pos` unchanged, `err`=1 and sticky. Then pulse `clr` coincident with a forward step → `pos`=0, `err`=0.
- WINDOW_CYCLES=1000, forward step every 20 cycles → `vel_valid` every 1000 cycles, `vel`=50 (±1 at boundary). Reverse at the same rate → `vel`=−50.
- VEL_W=4, 12 steps per window → `vel`=7 (saturated). Preload via clr and count 0 −1 → `pos`=0xFFFF_FFFF.
- With `QDEC_GLITCH_FILTER_EN` and FILT_CYCLES=4: a 3-cycle pulse on A → no step. A 5-cycle-stable edge → step, with latency 3+4 cycles.
